// File: rtl/program_loader_pkg.sv
// program_loader_pkg: frame header byte and loader FSM states
package program_loader_pkg;
  localparam logic [7:0] HEADER_BYTE = 8'hA5;
  typedef enum logic [2:0] {IDLE, COUNT, DATA, WRITE, CHECK, RUN, ERROR} state_t;
endpackage

// File: rtl/program_loader_word_assembler.sv
// program_loader_word_assembler: shifts LSB-first bytes into 32-bit words and keeps a running XOR checksum
module program_loader_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        done,
  output logic [7:0]  csum
);
  logic [1:0]  idx;
  logic [23:0] lanes;
  assign word = {byte_in, lanes};
  assign done = en && idx == 2'd3;
  always_ff @(posedge clk)
    if (rst || clear) begin
      idx   <= '0;
      lanes <= '0;
      csum  <= '0;
    end else if (en) begin
      idx   <= idx + 2'd1;
      lanes <= {byte_in, lanes[23:8]};
      csum  <= csum ^ byte_in;
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: receives a framed byte stream, writes instruction memory, then enables the core on a good checksum
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         ADDRESS_BITS = 5,
  parameter logic [7:0] HEADER       = HEADER_BYTE
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [7:0]              BYTE_IN,
  input  logic                    BYTE_VALID,
  output logic                    BYTE_READY,
  output logic                    W_EN,
  output logic [31:0]             W_INSTRUCTION,
  output logic [ADDRESS_BITS-1:0] ADDRESS,
  output logic                    R_EN,
  output logic                    BUSY,
  output logic                    ERR
);
  localparam int DEPTH = 2 ** ADDRESS_BITS;
  localparam int CW    = ADDRESS_BITS + 1;
  state_t        state, nxt;
  logic [CW-1:0] n, cnt, cnt_inc;
  logic [31:0]   word;
  logic [7:0]    csum;
  logic          take, clear, done, hdr;
  assign take    = BYTE_VALID && BYTE_READY;
  assign hdr     = take && BYTE_IN == HEADER;
  assign clear   = take && state == COUNT;
  assign cnt_inc = cnt + 1'b1;
  program_loader_word_assembler u_asm (
    .clk(CLK), .rst(RST), .clear(clear), .en(take && state == DATA),
    .byte_in(BYTE_IN), .word(word), .done(done), .csum(csum)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:       nxt = hdr ? COUNT : IDLE;
      COUNT:      if (take) nxt = (BYTE_IN == 8'd0 || {1'b0, BYTE_IN} > 9'(DEPTH)) ? ERROR : DATA;
      DATA:       nxt = done ? WRITE : DATA;
      WRITE:      nxt = cnt_inc == n ? CHECK : DATA;
      CHECK:      if (take) nxt = BYTE_IN == csum ? RUN : ERROR;
      RUN, ERROR: nxt = hdr ? COUNT : state;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK)
    if (RST) begin
      state         <= IDLE;
      BYTE_READY    <= 1'b1;
      W_EN          <= 1'b0;
      W_INSTRUCTION <= '0;
      ADDRESS       <= '0;
      R_EN          <= 1'b0;
      BUSY          <= 1'b0;
      ERR           <= 1'b0;
      n             <= '0;
      cnt           <= '0;
    end else begin
      state      <= nxt;
      BYTE_READY <= nxt != WRITE;
      W_EN       <= done;
      R_EN       <= nxt == RUN;
      ERR        <= nxt == ERROR;
      BUSY       <= nxt inside {COUNT, DATA, WRITE, CHECK};
      if (done) W_INSTRUCTION <= word;
      if (clear) begin
        n       <= CW'(BYTE_IN);
        cnt     <= '0;
        ADDRESS <= '0;
      end
      // the wide counter ends an N==DEPTH frame without the address wrapping
      if (state == WRITE) begin
        cnt <= cnt_inc;
        if (cnt_inc != n) ADDRESS <= ADDRESS + 1'b1;
      end
    end
endmodule
